// File: rtl/bellek_hakemi_if.sv
// Bus bundle for the memory arbiter: fetch request/response, data request/response and downstream port.
// Signal suffixes are from the arbiter's point of view; the arbiter uses "slave", a bench/upstream uses "master".
interface bellek_hakemi_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
);
    localparam int MASKE_BIT = VERI_BIT / 8;

    logic [ADRES_BIT-1:0] g_istek_adres_i;
    logic                 g_istek_gecerli_i;
    logic                 g_istek_hazir_o;
    logic [VERI_BIT-1:0]  g_yanit_veri_o;
    logic                 g_yanit_gecerli_o;
    logic                 g_yanit_hazir_i;
    logic                 g_bosalt_i;

    logic [ADRES_BIT-1:0] b_istek_adres_i;
    logic [VERI_BIT-1:0]  b_istek_veri_i;
    logic [MASKE_BIT-1:0] b_istek_maske_i;
    logic                 b_istek_yaz_i;
    logic                 b_istek_gecerli_i;
    logic                 b_istek_hazir_o;
    logic [VERI_BIT-1:0]  b_yanit_veri_o;
    logic                 b_yanit_gecerli_o;
    logic                 b_yanit_hazir_i;

    logic [ADRES_BIT-1:0] m_istek_adres_o;
    logic [VERI_BIT-1:0]  m_istek_veri_o;
    logic [MASKE_BIT-1:0] m_istek_maske_o;
    logic                 m_istek_yaz_o;
    logic                 m_istek_gecerli_o;
    logic                 m_istek_hazir_i;
    logic [VERI_BIT-1:0]  m_yanit_veri_i;
    logic                 m_yanit_gecerli_i;
    logic                 m_yanit_hazir_o;

    modport slave (
        input  g_istek_adres_i, g_istek_gecerli_i, g_yanit_hazir_i, g_bosalt_i,
        output g_istek_hazir_o, g_yanit_veri_o, g_yanit_gecerli_o,
        input  b_istek_adres_i, b_istek_veri_i, b_istek_maske_i, b_istek_yaz_i,
        input  b_istek_gecerli_i, b_yanit_hazir_i,
        output b_istek_hazir_o, b_yanit_veri_o, b_yanit_gecerli_o,
        output m_istek_adres_o, m_istek_veri_o, m_istek_maske_o, m_istek_yaz_o, m_istek_gecerli_o,
        input  m_istek_hazir_i, m_yanit_veri_i, m_yanit_gecerli_i,
        output m_yanit_hazir_o
    );

    modport master (
        output g_istek_adres_i, g_istek_gecerli_i, g_yanit_hazir_i, g_bosalt_i,
        input  g_istek_hazir_o, g_yanit_veri_o, g_yanit_gecerli_o,
        output b_istek_adres_i, b_istek_veri_i, b_istek_maske_i, b_istek_yaz_i,
        output b_istek_gecerli_i, b_yanit_hazir_i,
        input  b_istek_hazir_o, b_yanit_veri_o, b_yanit_gecerli_o,
        input  m_istek_adres_o, m_istek_veri_o, m_istek_maske_o, m_istek_yaz_o, m_istek_gecerli_o,
        output m_istek_hazir_i, m_yanit_veri_i, m_yanit_gecerli_i,
        input  m_yanit_hazir_o
    );
endinterface

// File: rtl/bellek_hakemi.sv
// Fetch/data arbiter onto one in-order memory port: one-entry issue register plus an owner tag FIFO
// that routes responses back and silently drops fetch responses cancelled by a flush.
module bellek_hakemi #(
    parameter int ADRES_BIT    = 32,
    parameter int VERI_BIT     = 32,
    parameter int MAX_BEKLEYEN = 4
) (
    input logic             clk_i,
    input logic             rstn_i,
    bellek_hakemi_if.slave  bus
);
    localparam int MASKE_BIT = VERI_BIT / 8;
    localparam int PTR_BIT   = $clog2(MAX_BEKLEYEN);
    localparam int SAY_BIT   = PTR_BIT + 1;
    localparam logic [SAY_BIT-1:0] SAY_MAX = SAY_BIT'(MAX_BEKLEYEN);
    localparam logic GETIR  = 1'b0;
    localparam logic BELLEK = 1'b1;

    typedef enum logic {IST_BOS = 1'b0, IST_DOLU = 1'b1} ist_durum_e;

    ist_durum_e             ist_q, ist_d;
    logic [ADRES_BIT-1:0]   adres_q, adres_d;
    logic [VERI_BIT-1:0]    veri_q, veri_d;
    logic [MASKE_BIT-1:0]   maske_q, maske_d;
    logic                   yaz_q, yaz_d;
    logic                   sahip_q, sahip_d;
    logic                   son_kazanan_q, son_kazanan_d;
    logic [MAX_BEKLEYEN-1:0] fifo_sahip_q, fifo_sahip_d;
    logic [MAX_BEKLEYEN-1:0] fifo_iptal_q, fifo_iptal_d;
    logic [PTR_BIT-1:0]     yaz_ptr_q, yaz_ptr_d;
    logic [PTR_BIT-1:0]     oku_ptr_q, oku_ptr_d;
    logic [SAY_BIT-1:0]     say_q, say_d;

    logic m_gecerli_s, m_kabul_s, yukle_s, g_gec_s, b_gec_s, kazanan_s;
    logic g_hazir_s, b_hazir_s, bos_degil_s, bas_sahip_s, bas_iptal_s;
    logic yanit_hazir_s, yanit_al_s, g_yanit_gec_s, b_yanit_gec_s;

    // Issue-side arbitration: a flushed fetch never competes, ties go to whoever did not win last.
    always_comb begin
        m_gecerli_s = (ist_q == IST_DOLU) && (say_q < SAY_MAX);
        m_kabul_s   = m_gecerli_s && bus.m_istek_hazir_i;
        yukle_s     = (ist_q == IST_BOS) || m_kabul_s;
        g_gec_s     = bus.g_istek_gecerli_i && !bus.g_bosalt_i;
        b_gec_s     = bus.b_istek_gecerli_i;
        if (g_gec_s && b_gec_s) begin
            kazanan_s = ~son_kazanan_q;
        end else if (g_gec_s) begin
            kazanan_s = GETIR;
        end else begin
            kazanan_s = BELLEK;
        end
        g_hazir_s = yukle_s && g_gec_s && (kazanan_s == GETIR);
        b_hazir_s = yukle_s && b_gec_s && (kazanan_s == BELLEK);
    end

    // Response routing from the FIFO head; a fetch head is treated as cancelled during a flush.
    always_comb begin
        bos_degil_s = (say_q != {SAY_BIT{1'b0}});
        bas_sahip_s = fifo_sahip_q[oku_ptr_q];
        bas_iptal_s = fifo_iptal_q[oku_ptr_q] || (bus.g_bosalt_i && (bas_sahip_s == GETIR));
        if (!bos_degil_s) begin
            yanit_hazir_s = 1'b0;
        end else if (bas_iptal_s) begin
            yanit_hazir_s = 1'b1;
        end else if (bas_sahip_s == GETIR) begin
            yanit_hazir_s = bus.g_yanit_hazir_i;
        end else begin
            yanit_hazir_s = bus.b_yanit_hazir_i;
        end
        yanit_al_s    = bus.m_yanit_gecerli_i && yanit_hazir_s;
        g_yanit_gec_s = bus.m_yanit_gecerli_i && bos_degil_s && (bas_sahip_s == GETIR) && !bas_iptal_s;
        b_yanit_gec_s = bus.m_yanit_gecerli_i && bos_degil_s && (bas_sahip_s == BELLEK) && !bas_iptal_s;
    end

    // Next state of the issue register and the tag FIFO.
    always_comb begin
        ist_d         = ist_q;
        adres_d       = adres_q;
        veri_d        = veri_q;
        maske_d       = maske_q;
        yaz_d         = yaz_q;
        sahip_d       = sahip_q;
        son_kazanan_d = son_kazanan_q;
        if (g_hazir_s || b_hazir_s) begin
            ist_d         = IST_DOLU;
            sahip_d       = kazanan_s;
            son_kazanan_d = kazanan_s;
            if (kazanan_s == GETIR) begin
                adres_d = bus.g_istek_adres_i;
                veri_d  = {VERI_BIT{1'b0}};
                maske_d = {MASKE_BIT{1'b0}};
                yaz_d   = 1'b0;
            end else begin
                adres_d = bus.b_istek_adres_i;
                veri_d  = bus.b_istek_veri_i;
                maske_d = bus.b_istek_maske_i;
                yaz_d   = bus.b_istek_yaz_i;
            end
        end else if (m_kabul_s) begin
            ist_d = IST_BOS;
        end else if (bus.g_bosalt_i && (sahip_q == GETIR)) begin
            ist_d = IST_BOS;
        end else begin
            ist_d = ist_q;
        end

        fifo_sahip_d = fifo_sahip_q;
        // Owner bit 0 means fetch, so the inverted owner vector selects every fetch entry.
        if (bus.g_bosalt_i) begin
            fifo_iptal_d = fifo_iptal_q | ~fifo_sahip_q;
        end else begin
            fifo_iptal_d = fifo_iptal_q;
        end
        if (m_kabul_s) begin
            fifo_sahip_d[yaz_ptr_q] = sahip_q;
            fifo_iptal_d[yaz_ptr_q] = bus.g_bosalt_i && (sahip_q == GETIR);
            yaz_ptr_d               = yaz_ptr_q + PTR_BIT'(1);
        end else begin
            yaz_ptr_d = yaz_ptr_q;
        end
        if (yanit_al_s) begin
            oku_ptr_d = oku_ptr_q + PTR_BIT'(1);
        end else begin
            oku_ptr_d = oku_ptr_q;
        end
        if (m_kabul_s && !yanit_al_s) begin
            say_d = say_q + SAY_BIT'(1);
        end else if (!m_kabul_s && yanit_al_s) begin
            say_d = say_q - SAY_BIT'(1);
        end else begin
            say_d = say_q;
        end
    end

    // State registers; reset drops every outstanding request and favours fetch on the first tie.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ist_q         <= IST_BOS;
            adres_q       <= {ADRES_BIT{1'b0}};
            veri_q        <= {VERI_BIT{1'b0}};
            maske_q       <= {MASKE_BIT{1'b0}};
            yaz_q         <= 1'b0;
            sahip_q       <= GETIR;
            son_kazanan_q <= BELLEK;
            fifo_sahip_q  <= {MAX_BEKLEYEN{1'b0}};
            fifo_iptal_q  <= {MAX_BEKLEYEN{1'b0}};
            yaz_ptr_q     <= {PTR_BIT{1'b0}};
            oku_ptr_q     <= {PTR_BIT{1'b0}};
            say_q         <= {SAY_BIT{1'b0}};
        end else begin
            ist_q         <= ist_d;
            adres_q       <= adres_d;
            veri_q        <= veri_d;
            maske_q       <= maske_d;
            yaz_q         <= yaz_d;
            sahip_q       <= sahip_d;
            son_kazanan_q <= son_kazanan_d;
            fifo_sahip_q  <= fifo_sahip_d;
            fifo_iptal_q  <= fifo_iptal_d;
            yaz_ptr_q     <= yaz_ptr_d;
            oku_ptr_q     <= oku_ptr_d;
            say_q         <= say_d;
        end
    end

    assign bus.g_istek_hazir_o   = g_hazir_s;
    assign bus.b_istek_hazir_o   = b_hazir_s;
    assign bus.m_istek_adres_o   = adres_q;
    assign bus.m_istek_veri_o    = veri_q;
    assign bus.m_istek_maske_o   = maske_q;
    assign bus.m_istek_yaz_o     = yaz_q;
    assign bus.m_istek_gecerli_o = m_gecerli_s;
    assign bus.m_yanit_hazir_o   = yanit_hazir_s;
    assign bus.g_yanit_veri_o    = bus.m_yanit_veri_i;
    assign bus.b_yanit_veri_o    = bus.m_yanit_veri_i;
    assign bus.g_yanit_gecerli_o = g_yanit_gec_s;
    assign bus.b_yanit_gecerli_o = b_yanit_gec_s;
endmodule

// File: tb/tb_bellek_hakemi.sv
// Scoreboard bench for bellek_hakemi: directed requests with hand-computed responses, an in-order
// downstream memory (read data = address ^ 0xEAAA_AAAA, write ack = write data) and a decoupled monitor.
module tb_bellek_hakemi;
    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;

    bellek_hakemi_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

    bellek_hakemi #(.ADRES_BIT(32), .VERI_BIT(32), .MAX_BEKLEYEN(4)) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] adres;
        logic [31:0] veri;
        logic [3:0]  maske;
        logic        yaz;
    } istek_t;

    typedef struct {
        logic [31:0] veri;
        int          hazir_cyc;
    } yanit_t;

    istek_t      g_gonder_q[$];
    istek_t      b_gonder_q[$];
    istek_t      m_bekle_q[$];
    logic [31:0] g_bekle_q[$];
    logic [31:0] b_bekle_q[$];
    yanit_t      asagi_q[$];

    int   kota;
    int   gecikme;
    logic mhz;
    logic g_bosalt;
    logic g_hz_desen;
    int   kabul_say;
    int   son_yanit_cyc;
    int   son_istek_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic istek_t ist(input logic [31:0] a, input logic [31:0] v,
                                   input logic [3:0] m, input logic y);
        istek_t r;
        r.adres = a;
        r.veri  = v;
        r.maske = m;
        r.yaz   = y;
        return r;
    endfunction

    task automatic kontrol(input string ad, input logic [95:0] gercek, input logic [95:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    task automatic bekle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Upstream requesters and downstream memory: sample handshakes at negedge, update after posedge.
    initial begin : surucu
        logic gk, bk, mk, yk;
        istek_t mi;
        bus.g_istek_adres_i = 32'h0; bus.g_istek_gecerli_i = 1'b0; bus.g_yanit_hazir_i = 1'b1;
        bus.g_bosalt_i = 1'b0;
        bus.b_istek_adres_i = 32'h0; bus.b_istek_veri_i = 32'h0; bus.b_istek_maske_i = 4'h0;
        bus.b_istek_yaz_i = 1'b0; bus.b_istek_gecerli_i = 1'b0; bus.b_yanit_hazir_i = 1'b1;
        bus.m_istek_hazir_i = 1'b0; bus.m_yanit_veri_i = 32'h0; bus.m_yanit_gecerli_i = 1'b0;
        forever begin
            @(negedge clk);
            gk = bus.g_istek_gecerli_i && bus.g_istek_hazir_o;
            bk = bus.b_istek_gecerli_i && bus.b_istek_hazir_o;
            mk = bus.m_istek_gecerli_o && bus.m_istek_hazir_i;
            yk = bus.m_yanit_gecerli_i && bus.m_yanit_hazir_o;
            mi = {bus.m_istek_adres_o, bus.m_istek_veri_o, bus.m_istek_maske_o, bus.m_istek_yaz_o};
            @(posedge clk);
            #1;
            if (!rstn) begin
                asagi_q.delete();
            end else begin
                if (gk) void'(g_gonder_q.pop_front());
                if (bk) void'(b_gonder_q.pop_front());
                if (yk) begin
                    void'(asagi_q.pop_front());
                    kota--;
                    son_yanit_cyc = cyc;
                end
                if (mk) begin
                    yanit_t y;
                    y.veri      = mi.yaz ? mi.veri : (mi.adres ^ 32'hEAAA_AAAA);
                    y.hazir_cyc = cyc + gecikme - 1;
                    asagi_q.push_back(y);
                    kabul_say++;
                    son_istek_cyc = cyc;
                end
            end
            bus.g_bosalt_i      = g_bosalt;
            bus.m_istek_hazir_i = mhz;
            bus.g_yanit_hazir_i = g_hz_desen ? ((cyc % 3) != 0) : 1'b1;
            bus.g_istek_gecerli_i = (g_gonder_q.size() > 0);
            bus.g_istek_adres_i   = (g_gonder_q.size() > 0) ? g_gonder_q[0].adres : 32'h0;
            if (b_gonder_q.size() > 0) begin
                bus.b_istek_gecerli_i = 1'b1;
                bus.b_istek_adres_i   = b_gonder_q[0].adres;
                bus.b_istek_veri_i    = b_gonder_q[0].veri;
                bus.b_istek_maske_i   = b_gonder_q[0].maske;
                bus.b_istek_yaz_i     = b_gonder_q[0].yaz;
            end else begin
                bus.b_istek_gecerli_i = 1'b0;
            end
            if (rstn && asagi_q.size() > 0 && kota > 0 && cyc >= asagi_q[0].hazir_cyc) begin
                bus.m_yanit_gecerli_i = 1'b1;
                bus.m_yanit_veri_i    = asagi_q[0].veri;
            end else begin
                bus.m_yanit_gecerli_i = 1'b0;
                bus.m_yanit_veri_i    = 32'h0;
            end
        end
    end

    // Monitor: every downstream issue and every delivered response is matched against the queues.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.m_istek_gecerli_o && bus.m_istek_hazir_i) begin
                    if (m_bekle_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL m_istek_fazla: got adres %h expected none", bus.m_istek_adres_o);
                    end else begin
                        kontrol("m_istek", {bus.m_istek_adres_o, bus.m_istek_veri_o,
                                bus.m_istek_maske_o, bus.m_istek_yaz_o}, m_bekle_q.pop_front());
                    end
                end
                if (bus.g_yanit_gecerli_o && bus.g_yanit_hazir_i) begin
                    if (g_bekle_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL g_yanit_fazla: got %h expected none", bus.g_yanit_veri_o);
                    end else begin
                        kontrol("g_yanit", bus.g_yanit_veri_o, g_bekle_q.pop_front());
                    end
                end
                if (bus.b_yanit_gecerli_o && bus.b_yanit_hazir_i) begin
                    if (b_bekle_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_yanit_fazla: got %h expected none", bus.b_yanit_veri_o);
                    end else begin
                        kontrol("b_yanit", bus.b_yanit_veri_o, b_bekle_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic bosalma_bekle(input string ad, input int butce);
        int n;
        n = 0;
        while ((g_gonder_q.size() + b_gonder_q.size() + m_bekle_q.size() + g_bekle_q.size()
                + b_bekle_q.size() + asagi_q.size()) != 0 && n < butce) begin
            @(posedge clk);
            n++;
        end
        kontrol(ad, (n < butce), 1'b1);
        bekle(2);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed tests.
    initial begin : ana
        logic [31:0] g_adr [8];
        logic [31:0] g_ver [8];
        int k0;
        g_adr = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C,
                  32'h4000_0010, 32'h4000_0014, 32'h4000_0018, 32'h4000_001C};
        g_ver = '{32'hAAAA_AAAA, 32'hAAAA_AAAE, 32'hAAAA_AAA2, 32'hAAAA_AAA6,
                  32'hAAAA_AABA, 32'hAAAA_AABE, 32'hAAAA_AAB2, 32'hAAAA_AAB6};
        cyc = 0; checks = 0; errors = 0; kabul_say = 0;
        son_yanit_cyc = 0; son_istek_cyc = 0;
        kota = 1000; gecikme = 2; mhz = 1'b1; g_bosalt = 1'b0; g_hz_desen = 1'b0;
        rstn = 1'b0;
        bekle(3);
        #1;
        kontrol("reset_m_istek_gecerli", bus.m_istek_gecerli_o, 1'b0);
        kontrol("reset_m_yanit_hazir", bus.m_yanit_hazir_o, 1'b0);
        kontrol("reset_g_yanit_gecerli", bus.g_yanit_gecerli_o, 1'b0);
        kontrol("reset_b_yanit_gecerli", bus.b_yanit_gecerli_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);

        // Contention right after reset: G,B,G,B,... and each side gets only its own data.
        for (int i = 0; i < 4; i++) g_gonder_q.push_back(ist(g_adr[i], 32'h0, 4'h0, 1'b0));
        b_gonder_q.push_back(ist(32'h8000_0000, 32'h0, 4'h0, 1'b0));
        b_gonder_q.push_back(ist(32'h8000_0004, 32'h1234_5678, 4'hF, 1'b1));
        b_gonder_q.push_back(ist(32'h8000_0008, 32'hCAFE_0000, 4'h3, 1'b1));
        b_gonder_q.push_back(ist(32'h8000_000C, 32'h0, 4'h0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            m_bekle_q.push_back(ist(g_adr[i], 32'h0, 4'h0, 1'b0));
            m_bekle_q.push_back(b_gonder_q[i]);
            g_bekle_q.push_back(g_ver[i]);
        end
        b_bekle_q.push_back(32'h6AAA_AAAA);
        b_bekle_q.push_back(32'h1234_5678);
        b_bekle_q.push_back(32'hCAFE_0000);
        b_bekle_q.push_back(32'h6AAA_AAA6);
        bosalma_bekle("t2_bosalma", 200);

        // Fetch only, 8 reads with response backpressure on the fetch side.
        g_hz_desen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g_gonder_q.push_back(ist(g_adr[i], 32'h0, 4'h0, 1'b0));
            m_bekle_q.push_back(ist(g_adr[i], 32'h0, 4'h0, 1'b0));
            g_bekle_q.push_back(g_ver[i]);
        end
        bosalma_bekle("t1_bosalma", 300);
        g_hz_desen = 1'b0;

        // Outstanding limit: 4 issued, 5th held, released one cycle after the first response.
        kota = 0;
        k0 = kabul_say;
        for (int i = 0; i < 5; i++) begin
            g_gonder_q.push_back(ist(32'h4000_0100 + 32'(4 * i), 32'h0, 4'h0, 1'b0));
            m_bekle_q.push_back(ist(32'h4000_0100 + 32'(4 * i), 32'h0, 4'h0, 1'b0));
        end
        g_bekle_q.push_back(32'hAAAA_ABAA);
        g_bekle_q.push_back(32'hAAAA_ABAE);
        g_bekle_q.push_back(32'hAAAA_ABA2);
        g_bekle_q.push_back(32'hAAAA_ABA6);
        g_bekle_q.push_back(32'hAAAA_ABBA);
        bekle(12);
        @(negedge clk);
        kontrol("t3_m_istek_gecerli_dolu", bus.m_istek_gecerli_o, 1'b0);
        kontrol("t3_kabul_4", kabul_say - k0, 4);
        kontrol("t3_5_kayitta", g_gonder_q.size(), 0);
        @(posedge clk);
        kota = 1;
        bekle(6);
        kontrol("t3_kabul_5", kabul_say - k0, 5);
        kontrol("t3_gecikme", son_istek_cyc - son_yanit_cyc, 1);
        kota = 1000;
        bosalma_bekle("t3_bosalma", 200);

        // Flush with G,B,G outstanding; a new fetch is offered during the flush cycle.
        kota = 0;
        g_gonder_q.push_back(ist(32'h4000_0200, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h4000_0200, 32'h0, 4'h0, 1'b0));
        bekle(3);
        b_gonder_q.push_back(ist(32'h8000_0200, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h8000_0200, 32'h0, 4'h0, 1'b0));
        bekle(3);
        g_gonder_q.push_back(ist(32'h4000_0204, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h4000_0204, 32'h0, 4'h0, 1'b0));
        bekle(3);
        g_bosalt = 1'b1;
        g_gonder_q.push_back(ist(32'h4000_0000, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h4000_0000, 32'h0, 4'h0, 1'b0));
        b_bekle_q.push_back(32'h6AAA_A8AA);
        g_bekle_q.push_back(32'hAAAA_AAAA);
        @(negedge clk);
        kontrol("t4_bosalt_g_hazir", bus.g_istek_hazir_o, 1'b0);
        @(posedge clk);
        g_bosalt = 1'b0;
        bekle(4);
        kota = 1000;
        bosalma_bekle("t4_bosalma", 200);

        // Flush in the very cycle the downstream takes a fetch: that response must vanish.
        mhz = 1'b0;
        g_gonder_q.push_back(ist(32'h4000_0300, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h4000_0300, 32'h0, 4'h0, 1'b0));
        bekle(3);
        g_bosalt = 1'b1;
        mhz = 1'b1;
        bekle(1);
        g_bosalt = 1'b0;
        bekle(8);
        b_gonder_q.push_back(ist(32'h8000_0300, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h8000_0300, 32'h0, 4'h0, 1'b0));
        b_bekle_q.push_back(32'h6AAA_A9AA);
        bosalma_bekle("t5_bosalma", 200);

        // Reset with two outstanding and one stalled request, then fetch must win the first tie.
        kota = 0;
        g_gonder_q.push_back(ist(32'h4000_0400, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h4000_0400, 32'h0, 4'h0, 1'b0));
        bekle(3);
        b_gonder_q.push_back(ist(32'h8000_0400, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h8000_0400, 32'h0, 4'h0, 1'b0));
        bekle(3);
        mhz = 1'b0;
        g_gonder_q.push_back(ist(32'h4000_0404, 32'h0, 4'h0, 1'b0));
        bekle(3);
        @(negedge clk);
        kontrol("t6_once_m_istek_gecerli", bus.m_istek_gecerli_o, 1'b1);
        kontrol("t6_once_m_yanit_hazir", bus.m_yanit_hazir_o, 1'b1);
        kontrol("t6_once_gonderim_bos", g_gonder_q.size() + m_bekle_q.size(), 0);
        #2;
        rstn = 1'b0;
        #1;
        kontrol("t6_m_istek_gecerli", bus.m_istek_gecerli_o, 1'b0);
        kontrol("t6_m_yanit_hazir", bus.m_yanit_hazir_o, 1'b0);
        kontrol("t6_g_yanit_gecerli", bus.g_yanit_gecerli_o, 1'b0);
        kontrol("t6_b_yanit_gecerli", bus.b_yanit_gecerli_o, 1'b0);
        bekle(2);
        mhz = 1'b1;
        kota = 1000;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        g_gonder_q.push_back(ist(32'h4000_0500, 32'h0, 4'h0, 1'b0));
        b_gonder_q.push_back(ist(32'h8000_0500, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h4000_0500, 32'h0, 4'h0, 1'b0));
        m_bekle_q.push_back(ist(32'h8000_0500, 32'h0, 4'h0, 1'b0));
        g_bekle_q.push_back(32'hAAAA_AFAA);
        b_bekle_q.push_back(32'h6AAA_AFAA);
        bosalma_bekle("t6_bosalma", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
